// File: rtl/mux_rr_nch_reg.sv
// N-channel arbitrated multiplexer with a single registered output stage.
// Round-robin or fixed-priority grant, valid/ready handshakes on both sides.
module mux_rr_nch_reg #(
    parameter int WIDTH     = 32,
    parameter int NCH       = 4,
    parameter int PRIO_MODE = 0,
    parameter int SRC_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SRC_W-1:0]     out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_any;
    logic             can_load;
    logic             transfer;
    logic [WIDTH-1:0] sel_data;

    assign can_load = !out_valid || out_ready;
    assign transfer = grant_any && can_load && rst_n;

    always_comb begin
        int cand;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        if (PRIO_MODE == 1) begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (in_valid[k]) begin
                    grant_idx = SRC_W'(k);
                    grant_any = 1'b1;
                end
            end
        end else begin
            // Scan starts one past the previous winner and wraps at NCH-1.
            for (int i = 1; i <= NCH; i++) begin
                cand = (int'(last_grant) + i) % NCH;
                if (!grant_any && in_valid[cand]) begin
                    grant_idx = SRC_W'(cand);
                    grant_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (SRC_W'(k) == grant_idx) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Held low during reset so no producer sees an accept that cannot land.
    assign in_ready = transfer ? (NCH'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            last_grant <= SRC_W'(NCH - 1);
        end else if (transfer) begin
            out_valid  <= 1'b1;
            out_data   <= sel_data;
            out_src    <= grant_idx;
            last_grant <= grant_idx;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_nch_reg.sv
// Directed bench for mux_rr_nch_reg: a round-robin instance and a fixed-priority
// instance share clock, reset and channel data.
module tb_mux_rr_nch_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_valid, in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_src;
    logic         out_valid, out_ready;
    logic [3:0]   in_valid_fp, in_ready_fp;
    logic [31:0]  out_data_fp;
    logic [1:0]   out_src_fp;
    logic         out_valid_fp, out_ready_fp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_rr_nch_reg #(.WIDTH(32), .NCH(4), .PRIO_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_src(out_src),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_rr_nch_reg #(.WIDTH(32), .NCH(4), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_fp),
        .in_ready(in_ready_fp), .out_data(out_data_fp), .out_src(out_src_fp),
        .out_valid(out_valid_fp), .out_ready(out_ready_fp)
    );

    function automatic logic [31:0] word(input int k);
        return 32'hA000_0000 | 32'(k);
    endfunction

    // Checks happen at the falling edge, then new inputs are applied there.
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (out_src !== 2'd0) begin failures++; $display("FAIL rst_out_src got=%0d exp=0", out_src); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
        checks++; if (out_valid_fp !== 1'b0) begin failures++; $display("FAIL rst_fp_out_valid got=%b exp=0", out_valid_fp); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL rst_first_ready got=%b exp=0001", in_ready); end
    endtask

    task automatic test_rr_sweep();
        int exp_src [6] = '{0, 1, 2, 3, 0, 1};
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d] got=%b exp=1", n, out_valid); end
            checks++; if (out_src !== 2'(exp_src[n])) begin failures++; $display("FAIL rr_src[%0d] got=%0d exp=%0d", n, out_src, exp_src[n]); end
            checks++; if (out_data !== word(exp_src[n])) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", n, out_data, word(exp_src[n])); end
            checks++; if (in_ready !== 4'(1 << ((exp_src[n] + 1) % 4))) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", n, in_ready, 4'(1 << ((exp_src[n] + 1) % 4))); end
        end
    endtask

    task automatic test_sparse();
        int exp_src [4] = '{3, 1, 3, 1};
        in_valid = 4'b1010;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++; if (out_src !== 2'(exp_src[n])) begin failures++; $display("FAIL sparse_src[%0d] got=%0d exp=%0d", n, out_src, exp_src[n]); end
            checks++; if (out_data !== word(exp_src[n])) begin failures++; $display("FAIL sparse_data[%0d] got=%h exp=%h", n, out_data, word(exp_src[n])); end
        end
        in_valid = 4'b0100;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++; if (out_src !== 2'd2 || out_valid !== 1'b1) begin failures++; $display("FAIL single_src[%0d] got=%0d/%b exp=2/1", n, out_src, out_valid); end
            checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL single_ready[%0d] got=%b exp=0100", n, in_ready); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 4'hF;
        #1;
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready_now got=%b exp=0000", in_ready); end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_src !== 2'd2) begin failures++; $display("FAIL bp_hold[%0d] got=%b/%0d exp=1/2", n, out_valid, out_src); end
            checks++; if (out_data !== word(2)) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", n, out_data, word(2)); end
            checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", n, in_ready); end
        end
        out_ready = 1'b1;
        #1;
        // Pointer held at 2 across the stall, so channel 3 is next.
        checks++; if (in_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%b exp=1000", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd3) begin failures++; $display("FAIL bp_reload got=%b/%0d exp=1/3", out_valid, out_src); end
        checks++; if (out_data !== word(3)) begin failures++; $display("FAIL bp_reload_data got=%h exp=%h", out_data, word(3)); end
        in_valid = 4'b0000;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== word(3) || out_src !== 2'd3) begin failures++; $display("FAIL drain_keep got=%h/%0d exp=%h/3", out_data, out_src, word(3)); end
    endtask

    task automatic test_fixed_prio();
        in_valid_fp = 4'b0101; out_ready_fp = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++; if (out_valid_fp !== 1'b1 || out_src_fp !== 2'd0) begin failures++; $display("FAIL fp_src[%0d] got=%b/%0d exp=1/0", n, out_valid_fp, out_src_fp); end
            checks++; if (in_ready_fp !== 4'b0001) begin failures++; $display("FAIL fp_ready[%0d] got=%b exp=0001", n, in_ready_fp); end
        end
        in_valid_fp = 4'b0100;
        #1;
        checks++; if (in_ready_fp !== 4'b0100) begin failures++; $display("FAIL fp_drop_ready got=%b exp=0100", in_ready_fp); end
        @(negedge clk);
        checks++; if (out_src_fp !== 2'd2 || out_data_fp !== word(2)) begin failures++; $display("FAIL fp_drop_src got=%0d/%h exp=2/%h", out_src_fp, out_data_fp, word(2)); end
        in_valid_fp = 4'b0000;
    endtask

    task automatic test_async_reset();
        in_valid = 4'b0001; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin failures++; $display("FAIL ar_load got=%b/%0d exp=1/0", out_valid, out_src); end
        out_ready = 1'b0; in_valid = 4'b1110;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin failures++; $display("FAIL ar_clear got=%b/%h exp=0/0", out_valid, out_data); end
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_src !== 2'd1) begin failures++; $display("FAIL ar_first_grant got=%b/%0d exp=1/1", out_valid, out_src); end
        checks++; if (out_data !== word(1)) begin failures++; $display("FAIL ar_first_data got=%h exp=%h", out_data, word(1)); end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = word(k);
        in_valid_fp = 4'b0000; out_ready_fp = 1'b1;
        test_reset();
        test_rr_sweep();
        test_sparse();
        test_backpressure();
        test_fixed_prio();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_nch_reg.md
Name: mux_rr_nch_reg

Overview:
- Parametrised N-channel, W-bit datapath multiplexer: successor to the fixed 2-channel select muxes.
- Control is no longer an external select line. The block arbitrates among requesting channels itself, round-robin or fixed-priority.
- The winning word goes into a single registered output stage with valid/ready handshakes on both sides.
- Used where several producers share one consumer, e.g. writeback or bus sources feeding the register file or a memory port.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- NCH, 4, number of input channels, 1..16.
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SRC_W, max(1, clog2(NCH)), width of the source-index output. Derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NCH*WIDTH  packed channel words; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel request.
- in_ready  out  NCH  per-channel accept. At most one bit is set in any cycle.
- out_data  out  WIDTH  registered selected word.
- out_src  out  SRC_W  index of the channel that supplied out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset is asynchronous on rst_n low, all outputs and state cleared:
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer last_grant = NCH-1, so channel 0 has first priority after reset.
  - in_ready is combinational and is therefore 0 while out stage is full-and-stalled.
- can_load = !out_valid || out_ready.
- Grant (combinational, one-hot or zero):
  - PRIO_MODE=0: scan channels starting at (last_grant+1) mod NCH, wrapping at NCH-1 to 0. The first channel with in_valid=1 wins.
  - PRIO_MODE=1: lowest index with in_valid=1 wins.
  - No valid input: no grant.
- in_ready[k] = can_load && grant==k. Transfer on channel k when in_valid[k] && in_ready[k].
- On a transfer at edge t:
  - out_data <= word k, out_src <= k, out_valid <= 1.
  - last_grant <= k (both modes update it; only mode 0 uses it).
- On out_valid && out_ready with no new transfer: out_valid <= 0. out_data and out_src keep their last values.
- Simultaneous drain and load: the new word replaces the old word in the same edge, out_valid stays 1. Sustained throughput is 1 word/cycle.
- Latency: input to out_valid is exactly 1 cycle.
- Stall: while out_valid && !out_ready:
  - out_data, out_src and out_valid hold.
  - All in_ready=0.
  - last_grant holds.
- Arbitration considers only in_valid. Grant may change between cycles while stalled. No lock is held on a non-transferred request.
- Fairness (mode 0): with all NCH channels continuously valid and out_ready=1, grants follow 0,1,...,NCH-1,0,...
- NCH=1: grant = in_valid[0], out_src constant 0.
- Reset mid-operation: a held output word is discarded with no partial transfer. After release, the first grant in mode 0 goes to the lowest valid index.
- No combinational path from in_data to out_data. The only paths from out_ready to in_ready go through can_load.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0, out_src=0, in_ready=0. Release with out_ready=1 -> first transfer from channel 0; one cycle later out_data = ch0 word, out_src=0.
- Round-robin sweep (NCH=4, WIDTH=32, mode 0): channels k carry 0xA000_000k, all valid, out_ready=1 -> out_src sequence 0,1,2,3,0,1, out_valid=1 every cycle after the first, one transfer per cycle.
- Sparse requests (mode 0): valid only on ch1 and ch3 after last_grant=1 -> order 3,1,3,1. Then only ch2 valid -> ch2 granted every cycle.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_src constant, in_ready=0000, last_grant unchanged. out_ready=1 -> drain and a new load in the same edge, out_valid stays 1.
- Fixed priority (PRIO_MODE=1): ch0 and ch2 valid continuously -> ch0 always granted, ch2 in_ready=0. Drop ch0 -> ch2 granted the next cycle.
- Async reset mid-stall: out_valid=1, out_ready=0, pulse rst_n low between edges -> out_valid=0 immediately without waiting for a clock edge. After release the next grant goes to the lowest valid channel.
